result_serializer: RTL and testbench

- Output-side counterpart of the switch operand loader in the FPU top level.
- Captures one 32-bit FPU result plus its 5-bit exception flags through a valid/ready handshake.
- Presents the capture on the 16-bit led bus as three successive words: low half, high half, flags.
- Uses the same low-half-first order the switch loader uses on input.
- Sits between the FPU core's result port and the board LEDs.

---
 rtl/result_serializer.sv | 120 ++++++++++++
 tb/tb_result_serializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// Shows one captured FPU result on the 16-bit LED bus as three words:
// low half, high half, then the 5 exception flags (optionally looping).
module result_serializer #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned LOOP        = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic [4:0]  in_flags,
    output logic [15:0] led,
    output logic [1:0]  led_phase,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2,
        FLAGS = 2'd3
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam bit          LOOP_EN   = (LOOP != 0);

    state_t      state, state_next;
    logic [15:0] hold_cnt;
    logic [31:0] res_q;
    logic [4:0]  flags_q;

    logic        hold_last;
    logic        transfer;
    logic [31:0] res_next;
    logic [4:0]  flags_next;
    logic [15:0] led_next;
    logic        done_next;

    assign hold_last = (hold_cnt == HOLD_LAST);
    assign transfer  = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b0;
        if (state == IDLE)
            in_ready = 1'b1;
        else if (LOOP_EN && state == FLAGS && hold_last)
            in_ready = 1'b1;
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (transfer)
                    state_next = LOW;
            end
            LOW: begin
                if (hold_last)
                    state_next = HIGH;
            end
            HIGH: begin
                if (hold_last)
                    state_next = FLAGS;
            end
            FLAGS: begin
                if (hold_last) begin
                    if (LOOP_EN) begin
                        state_next = LOW;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // led is registered from the next state so the low half appears on the
    // cycle right after the accepting edge, using the freshly captured data.
    always_comb begin
        res_next   = transfer ? in_result : res_q;
        flags_next = transfer ? in_flags  : flags_q;
        led_next   = led;
        unique case (state_next)
            LOW:     led_next = res_next[15:0];
            HIGH:    led_next = res_next[31:16];
            FLAGS:   led_next = {11'b0, flags_next};
            default: led_next = led;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            led      <= '0;
            done     <= 1'b0;
        end else begin
            state   <= state_next;
            res_q   <= res_next;
            flags_q <= flags_next;
            led     <= led_next;
            done    <= done_next;
            if (state_next != state || state_next == IDLE)
                hold_cnt <= '0;
            else
                hold_cnt <= hold_cnt + 16'd1;
        end
    end

    assign led_phase = state;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: three instances cover
// HOLD=1/LOOP=0, HOLD=4/LOOP=0 and HOLD=2/LOOP=1.
module tb_result_serializer;

    logic        clk;
    logic        rst       [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] in_result [3];
    logic [4:0]  in_flags  [3];
    logic [15:0] led       [3];
    logic [1:0]  led_phase [3];
    logic        busy      [3];
    logic        done      [3];

    int vectors;
    int miscompares;

    typedef struct {
        logic [15:0] led;
        logic [1:0]  phase;
        logic        ready;
    } exp_t;

    exp_t sb[$];

    result_serializer #(.HOLD_CYCLES(1), .LOOP(0)) dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_result(in_result[0]), .in_flags(in_flags[0]), .led(led[0]),
        .led_phase(led_phase[0]), .busy(busy[0]), .done(done[0])
    );

    result_serializer #(.HOLD_CYCLES(4), .LOOP(0)) dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_result(in_result[1]), .in_flags(in_flags[1]), .led(led[1]),
        .led_phase(led_phase[1]), .busy(busy[1]), .done(done[1])
    );

    result_serializer #(.HOLD_CYCLES(2), .LOOP(1)) dut2 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_result(in_result[2]), .in_flags(in_flags[2]), .led(led[2]),
        .led_phase(led_phase[2]), .busy(busy[2]), .done(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] r, input logic [4:0] f,
                              input int unsigned hold, input logic loop_en);
        logic [15:0] w;
        for (int unsigned p = 1; p <= 3; p++) begin
            w = (p == 1) ? r[15:0] : (p == 2) ? r[31:16] : {11'b0, f};
            for (int unsigned h = 0; h < hold; h++)
                sb.push_back('{w, 2'(p), loop_en && p == 3 && h == hold - 1});
        end
    endtask

    task automatic drain(input int d, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            if (sb.size() == 0) begin
                chk($sformatf("sb_empty_d%0d", d), 32'd0, 32'd1);
                return;
            end
            e = sb.pop_front();
            chk($sformatf("led_d%0d", d),   32'(led[d]),       32'(e.led));
            chk($sformatf("phase_d%0d", d), 32'(led_phase[d]), 32'(e.phase));
            chk($sformatf("busy_d%0d", d),  32'(busy[d]),      32'd1);
            chk($sformatf("ready_d%0d", d), 32'(in_ready[d]),  32'(e.ready));
            chk($sformatf("done_d%0d", d),  32'(done[d]),      32'd0);
        end
    endtask

    task automatic send(input int d, input logic [31:0] r, input logic [4:0] f);
        in_result[d] = r;
        in_flags[d]  = f;
        in_valid[d]  = 1'b1;
        chk($sformatf("send_ready_d%0d", d), 32'(in_ready[d]), 32'd1);
        step();
        in_valid[d] = 1'b0;
    endtask

    task automatic check_idle(input int d, input logic [15:0] exp_led, input logic exp_done);
        chk($sformatf("idle_led_d%0d", d),   32'(led[d]),       32'(exp_led));
        chk($sformatf("idle_phase_d%0d", d), 32'(led_phase[d]), 32'd0);
        chk($sformatf("idle_busy_d%0d", d),  32'(busy[d]),      32'd0);
        chk($sformatf("idle_ready_d%0d", d), 32'(in_ready[d]),  32'd1);
        chk($sformatf("idle_done_d%0d", d),  32'(done[d]),      32'(exp_done));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int d = 0; d < 3; d++) begin
            rst[d]       = 1'b1;
            in_valid[d]  = 1'b0;
            in_result[d] = 32'hDEAD_BEEF;
            in_flags[d]  = 5'h1F;
        end

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        for (int d = 0; d < 3; d++) check_idle(d, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle(0, 16'h0000, 1'b0);
        end

        // HOLD=1 single frame: back-to-back words, then done in first IDLE cycle
        send(0, 32'h41BE_0000, 5'b00000);
        push_frame(32'h41BE_0000, 5'b00000, 1, 1'b0);
        drain(0, 3);
        step();
        check_idle(0, 16'h0000, 1'b1);
        step();
        check_idle(0, 16'h0000, 1'b0);

        // HOLD=4 frame with nonzero flags
        send(1, 32'h7F80_0000, 5'b00101);
        push_frame(32'h7F80_0000, 5'b00101, 4, 1'b0);
        drain(1, 12);
        step();
        check_idle(1, 16'h0005, 1'b1);
        step();
        check_idle(1, 16'h0005, 1'b0);

        // Backpressure: in_valid held with new data throughout the first frame
        in_result[1] = 32'h4194_0000;
        in_flags[1]  = 5'b00001;
        in_valid[1]  = 1'b1;
        step();
        in_result[1] = 32'h40A8_0000;
        in_flags[1]  = 5'b10000;
        push_frame(32'h4194_0000, 5'b00001, 4, 1'b0);
        drain(1, 12);
        step();
        check_idle(1, 16'h0001, 1'b1);
        push_frame(32'h40A8_0000, 5'b10000, 4, 1'b0);
        step();
        in_valid[1] = 1'b0;
        drain(1, 12);
        step();
        check_idle(1, 16'h0010, 1'b1);

        // Reset during HIGH phase aborts without done
        step();
        send(1, 32'h1234_5678, 5'b11111);
        push_frame(32'h1234_5678, 5'b11111, 4, 1'b0);
        drain(1, 6);
        sb.delete();
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        check_idle(1, 16'h0000, 1'b0);
        step();
        check_idle(1, 16'h0000, 1'b0);
        send(1, 32'hABCD_0123, 5'b01010);
        push_frame(32'hABCD_0123, 5'b01010, 4, 1'b0);
        drain(1, 12);
        step();
        check_idle(1, 16'h000A, 1'b1);

        // LOOP=1: repeats without done; held in_valid accepted on last FLAGS cycle
        send(2, 32'h41BE_0000, 5'b00011);
        push_frame(32'h41BE_0000, 5'b00011, 2, 1'b1);
        push_frame(32'h41BE_0000, 5'b00011, 2, 1'b1);
        drain(2, 7);
        in_result[2] = 32'hC0A0_0000;
        in_flags[2]  = 5'b00000;
        in_valid[2]  = 1'b1;
        step();
        drain(2, 5);
        push_frame(32'hC0A0_0000, 5'b00000, 2, 1'b1);
        push_frame(32'hC0A0_0000, 5'b00000, 2, 1'b1);
        step();
        in_valid[2] = 1'b0;
        drain(2, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
